// File: rtl/fpu_issue.sv
// Issue/writeback sequencer in front of the FPU: accepts one op at a time, pulses
// the FPU, waits for its result (with a timeout) and returns it on a ready/valid port.
module fpu_issue #(
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic            CLK,
    input  logic            INITIALIZE,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [2:0]      req_subop,
    input  logic [31:0]     req_a,
    input  logic [31:0]     req_b,
    input  logic [RD_W-1:0] req_rd,
    output logic            fpu_in_valid,
    output logic [2:0]      fpu_operator,
    output logic [2:0]      fpu_subop,
    output logic [31:0]     fpu_a,
    output logic [31:0]     fpu_b,
    input  logic            fpu_result_valid,
    input  logic [31:0]     fpu_c,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data,
    output logic            wb_to_int,
    output logic            wb_err,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    localparam logic [2:0]       OP_CMP   = 3'd5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_d;
    logic             fpu_in_valid_d;
    logic [2:0]       fpu_operator_d;
    logic [2:0]       fpu_subop_d;
    logic [31:0]      fpu_a_d;
    logic [31:0]      fpu_b_d;
    logic             wb_valid_d;
    logic [RD_W-1:0]  wb_rd_d;
    logic [31:0]      wb_data_d;
    logic             wb_to_int_d;
    logic             wb_err_d;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_d;

    logic accept;
    logic op_illegal;

    // Ready is held low during reset so decode never sees a phantom accept.
    assign req_ready  = (state == IDLE) && !INITIALIZE;
    assign busy       = (state != IDLE);
    assign accept     = req_valid && req_ready;
    assign op_illegal = (req_op[2:1] == 2'b11);

    always_comb begin
        // NOTE: every next-value starts as the current register value, so no branch can leave one unassigned and infer a latch.
        state_d        = state;
        fpu_in_valid_d = fpu_in_valid;
        fpu_operator_d = fpu_operator;
        fpu_subop_d    = fpu_subop;
        fpu_a_d        = fpu_a;
        fpu_b_d        = fpu_b;
        wb_valid_d     = wb_valid;
        wb_rd_d        = wb_rd;
        wb_data_d      = wb_data;
        wb_to_int_d    = wb_to_int;
        wb_err_d       = wb_err;
        wait_cnt_d     = wait_cnt;

        case (state)
            IDLE: begin
                if (accept) begin
                    fpu_operator_d = req_op;
                    fpu_subop_d    = req_subop;
                    fpu_a_d        = req_a;
                    fpu_b_d        = req_b;
                    wb_rd_d        = req_rd;
                    wb_to_int_d    = (req_op == OP_CMP);
                    if (op_illegal) begin
                        state_d    = WB;
                        wb_valid_d = 1'b1;
                        wb_err_d   = 1'b1;
                        wb_data_d  = '0;
                    end else begin
                        state_d        = ISSUE;
                        fpu_in_valid_d = 1'b1;
                    end
                end
            end

            ISSUE: begin
                state_d        = WAIT;
                fpu_in_valid_d = 1'b0;
                wait_cnt_d     = '0;
            end

            // The FPU bus is left untouched here: the FPU muxes its result by operator.
            WAIT: begin
                if (fpu_result_valid) begin
                    state_d    = WB;
                    wb_valid_d = 1'b1;
                    wb_data_d  = fpu_c;
                    wb_err_d   = 1'b0;
                end else if (wait_cnt == CNT_LAST) begin
                    state_d    = WB;
                    wb_valid_d = 1'b1;
                    wb_data_d  = '0;
                    wb_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt + CNT_W'(1);
                end
            end

            WB: begin
                if (wb_ready) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (INITIALIZE) begin
            state        <= IDLE;
            fpu_in_valid <= 1'b0;
            fpu_operator <= '0;
            fpu_subop    <= '0;
            fpu_a        <= '0;
            fpu_b        <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_to_int    <= 1'b0;
            wb_err       <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            state        <= state_d;
            fpu_in_valid <= fpu_in_valid_d;
            fpu_operator <= fpu_operator_d;
            fpu_subop    <= fpu_subop_d;
            fpu_a        <= fpu_a_d;
            fpu_b        <= fpu_b_d;
            wb_valid     <= wb_valid_d;
            wb_rd        <= wb_rd_d;
            wb_data      <= wb_data_d;
            wb_to_int    <= wb_to_int_d;
            wb_err       <= wb_err_d;
            wait_cnt     <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_fpu_issue.sv
// Scoreboard bench for fpu_issue: an FPU model with programmable latency and a
// queue of expected writebacks checked at each handshake.
module tb_fpu_issue;

    localparam int RD_W    = 5;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [31:0]     data;
        logic            to_int;
        logic            err;
    } wb_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  subop;
        logic [31:0] a;
        logic [31:0] b;
    } bus_t;

    logic            CLK = 1'b0;
    logic            INITIALIZE;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [2:0]      req_subop;
    logic [31:0]     req_a;
    logic [31:0]     req_b;
    logic [RD_W-1:0] req_rd;
    logic            fpu_in_valid;
    logic [2:0]      fpu_operator;
    logic [2:0]      fpu_subop;
    logic [31:0]     fpu_a;
    logic [31:0]     fpu_b;
    logic            fpu_result_valid;
    logic [31:0]     fpu_c;
    logic            wb_valid;
    logic            wb_ready;
    logic [RD_W-1:0] wb_rd;
    logic [31:0]     wb_data;
    logic            wb_to_int;
    logic            wb_err;
    logic            busy;

    fpu_issue #(.RD_W(RD_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .INITIALIZE(INITIALIZE),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_subop(req_subop), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .fpu_in_valid(fpu_in_valid), .fpu_operator(fpu_operator),
        .fpu_subop(fpu_subop), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_result_valid(fpu_result_valid), .fpu_c(fpu_c),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_to_int(wb_to_int), .wb_err(wb_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    wb_t         sb[$];
    wb_t         pend_wb;
    bus_t        pend_bus;
    bus_t        cur_bus;
    bit          acc_seen;
    int          pulses;
    int          wait_cycles;
    int          mdl_cnt = -1;
    int          mdl_lat;
    logic [31:0] mdl_res;
    bit          mdl_fired;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: score the handshake, advance, then observe and run the FPU model.
    task automatic step();
        bit  acc;
        bit  hs;
        wb_t exp;
        acc = req_valid && req_ready;
        hs  = wb_valid && wb_ready;
        if (hs) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", wb_valid, 1'b0);
            end else begin
                exp = sb.pop_front();
                check("wb_handshake", {wb_rd, wb_data, wb_to_int, wb_err}, exp);
            end
        end
        @(posedge CLK);
        #1;
        if (acc) begin
            sb.push_back(pend_wb);
            cur_bus     = pend_bus;
            acc_seen    = 1'b1;
            wait_cycles = 0;
        end
        if (hs) check("busy_after_hs", busy, 1'b0);
        if (fpu_in_valid) pulses++;
        if (busy && !fpu_in_valid && !wb_valid) wait_cycles++;
        if (busy) check("fpu_bus_held", {fpu_operator, fpu_subop, fpu_a, fpu_b}, cur_bus);
        if (wb_valid) begin
            check("req_ready_in_wb", req_ready, 1'b0);
            if (sb.size() > 0) check("wb_hold", {wb_rd, wb_data, wb_to_int, wb_err}, sb[0]);
        end
        fpu_result_valid = 1'b0;
        fpu_c            = 32'hDEAD_BEEF;
        if (fpu_in_valid) begin
            mdl_cnt = mdl_lat;
        end else if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0) begin
                fpu_result_valid = 1'b1;
                fpu_c            = mdl_res;
                mdl_fired        = 1'b1;
                mdl_cnt          = -1;
            end
        end
    endtask

    // lat = cycles from the issue pulse to result_valid; 0 means the FPU never answers.
    task automatic drive(input logic [2:0] op, input logic [2:0] subop, input logic [31:0] a,
                         input logic [31:0] b, input logic [RD_W-1:0] rd,
                         input logic [31:0] res, input int lat);
        bit err;
        err      = (op >= 3'd6) || (lat == 0) || (lat > TIMEOUT);
        pend_wb  = '{rd: rd, data: err ? 32'h0 : res, to_int: (op == 3'd5), err: err};
        pend_bus = '{op: op, subop: subop, a: a, b: b};
        mdl_lat  = lat;
        mdl_res  = res;
        req_op = op; req_subop = subop; req_a = a; req_b = b; req_rd = rd;
        req_valid = 1'b1;
        acc_seen  = 1'b0;
    endtask

    task automatic await_accept();
        for (int i = 0; i < 40 && !acc_seen; i++) step();
        check("accept", acc_seen, 1'b1);
        req_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] subop, input logic [31:0] a,
                        input logic [31:0] b, input logic [RD_W-1:0] rd,
                        input logic [31:0] res, input int lat);
        drive(op, subop, a, b, rd, res, lat);
        await_accept();
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() > 0; i++) step();
        check("drain", sb.size(), 0);
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {fpu_in_valid, fpu_operator, fpu_subop, fpu_a, fpu_b, wb_valid,
                    wb_rd, wb_data, wb_to_int, wb_err, busy}, '0);
    endtask

    initial begin
        INITIALIZE = 1'b1; req_valid = 1'b0; req_op = '0; req_subop = '0;
        req_a = '0; req_b = '0; req_rd = '0; wb_ready = 1'b1;
        fpu_result_valid = 1'b0; fpu_c = '0; mdl_lat = 0; mdl_res = '0;
        step(); step();
        check_all_zero("reset_outputs");
        check("req_ready_in_reset", req_ready, 1'b0);
        INITIALIZE = 1'b0;
        #1;
        check("req_ready_idle", req_ready, 1'b1);

        // ADD with a 5-cycle FPU
        pulses = 0;
        send(3'd1, 3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd3, 32'h4040_0000, 5);
        drain();
        check("add_pulses", pulses, 1);
        check("add_wait_cycles", wait_cycles, 5);

        // CMP to the integer file
        send(3'd5, 3'd2, 32'h4000_0000, 32'h3F80_0000, 5'd7, 32'h0000_0001, 2);
        drain();

        // MUL under writeback backpressure; a competing request must wait for IDLE
        wb_ready = 1'b0;
        send(3'd3, 3'd0, 32'h4000_0000, 32'h4040_0000, 5'd9, 32'h40C0_0000, 1);
        for (int i = 0; i < 20 && !wb_valid; i++) step();
        check("bp_wb_valid", wb_valid, 1'b1);
        drive(3'd1, 3'd0, 32'h4000_0000, 32'h4000_0000, 5'd12, 32'h4080_0000, 3);
        for (int i = 0; i < 6; i++) step();
        check("bp_no_accept", acc_seen, 1'b0);
        check("bp_still_valid", wb_valid, 1'b1);
        wb_ready = 1'b1;
        await_accept();
        drain();

        // Timeout: no result ever, then a result on the last WAIT cycle
        send(3'd4, 3'd0, 32'h4120_0000, 32'h0, 5'd4, 32'h0, 0);
        drain();
        check("timeout_wait_cycles", wait_cycles, TIMEOUT);
        send(3'd4, 3'd0, 32'h4120_0000, 32'h4000_0000, 5'd5, 32'h40A0_0000, TIMEOUT);
        drain();
        check("late_wait_cycles", wait_cycles, TIMEOUT);

        // Illegal op: straight to an error writeback, FPU untouched
        pulses = 0;
        send(3'd7, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21, 32'h0, 1);
        check("illegal_wb_next_cycle", wb_valid, 1'b1);
        drain();
        check("illegal_pulses", pulses, 0);

        // Reset in the middle of a DIV; the late result must be dropped
        mdl_fired = 1'b0;
        send(3'd4, 3'd0, 32'h40C0_0000, 32'h4000_0000, 5'd11, 32'h4040_0000, 6);
        step(); step(); step();
        INITIALIZE = 1'b1;
        #1;
        check("req_ready_forced_low", req_ready, 1'b0);
        step();
        check_all_zero("reset_mid_wait");
        sb.delete();
        INITIALIZE = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("no_wb_after_reset", wb_valid, 1'b0);
        end
        check("late_result_fired", mdl_fired, 1'b1);
        send(3'd1, 3'd0, 32'h3F80_0000, 32'h3F80_0000, 5'd30, 32'h4000_0000, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
